// File: rtl/arm_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, datapath mux selects, ALU commands and condition codes.
package arm_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] PC_REG  = 4'd15;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Unsupported data-processing commands fall back to an add.
  function automatic logic [1:0] alu_decode(input logic alu_op, input logic [3:0] cmd);
    logic [1:0] ctl;
    ctl = ALU_ADD;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: ctl = ALU_ADD;
        CMD_SUB: ctl = ALU_SUB;
        CMD_AND: ctl = ALU_AND;
        CMD_ORR: ctl = ALU_ORR;
        default: ctl = ALU_ADD;
      endcase
    end else begin
      ctl = ALU_ADD;
    end
    return ctl;
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// Instruction-field inputs, memory handshake and datapath control strobes
// exchanged between the control unit (master) and the datapath (slave).
interface arm_multicycle_ctrl_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/arm_multicycle_ctrl_cond.sv
// Condition unit: NZCV flag register, per-instruction condition latch
// captured in DECODE, and S-bit gated flag updates during execute.
module arm_multicycle_ctrl_cond
  import arm_multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_sample,
  input  logic       i_exec,
  input  logic       i_s,
  input  logic [3:0] i_cmd,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;
  logic       r_cond_ex;
  logic       w_cond_ex;
  logic       w_n, w_z, w_c, w_v;
  logic       w_upd_nz;
  logic       w_upd_cv;

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign w_upd_nz  = i_exec & i_s & r_cond_ex;
  assign w_upd_cv  = w_upd_nz & ((i_cmd == CMD_ADD) | (i_cmd == CMD_SUB));
  assign o_cond_ex = r_cond_ex;

  // ARM condition evaluation; the 1111 encoding never executes.
  always_comb begin
    w_cond_ex = 1'b0;
    case (i_cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = ~(w_n ^ w_v);
      4'b1011: w_cond_ex = w_n ^ w_v;
      4'b1100: w_cond_ex = ~w_z & ~(w_n ^ w_v);
      4'b1101: w_cond_ex = w_z | (w_n ^ w_v);
      COND_AL: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Condition latch and flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cond_ex <= 1'b0;
      r_flags   <= 4'b0000;
    end else begin
      if (i_sample) begin
        r_cond_ex <= w_cond_ex;
      end
      if (w_upd_nz) begin
        r_flags[3:2] <= i_alu_flags[3:2];
      end
      if (w_upd_cv) begin
        r_flags[1:0] <= i_alu_flags[1:0];
      end
    end
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM with memory-ready stalls, ALU decode
// and condition-gated write strobes.
module arm_multicycle_ctrl (
  input  logic                   clk,
  input  logic                   reset_n,
  arm_multicycle_ctrl_if.master  bus
);
  import arm_multicycle_ctrl_pkg::*;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_next_pc, w_ir_write, w_reg_w, w_mem_w, w_branch, w_alu_op;
  logic       w_adr_src, w_alu_src_a;
  logic [1:0] w_result_src, w_alu_src_b;
  logic       w_cond_ex;
  logic       w_pcs;

  arm_multicycle_ctrl_cond u_cond (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_cond      (bus.Cond),
    .i_alu_flags (bus.ALUFlags),
    .i_sample    (r_state == S_DECODE),
    .i_exec      ((r_state == S_EXECUTER) | (r_state == S_EXECUTEI)),
    .i_s         (bus.Funct[0]),
    .i_cmd       (bus.Funct[4:1]),
    .o_cond_ex   (w_cond_ex)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          2'b01:   w_next_state = S_MEMADR;
          2'b00:   w_next_state = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next_state = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWR:    w_next_state = bus.MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_EXECUTEI: w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Raw per-state controls before condition gating.
  always_comb begin
    w_next_pc    = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 1'b0;
    w_adr_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_result_src = RES_ALUOUT;
    w_alu_src_b  = SRCB_WD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_next_pc    = bus.MemReady;
        w_ir_write   = bus.MemReady;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
      end
      S_MEMADR:   w_alu_src_b = SRCB_IMM;
      S_MEMRD:    w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_w      = 1'b1;
      end
      S_MEMWR: begin
        w_adr_src = 1'b1;
        w_mem_w   = 1'b1;
      end
      S_EXECUTER: w_alu_op = 1'b1;
      S_EXECUTEI: begin
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = 1'b1;
      end
      S_ALUWB:    w_reg_w = 1'b1;
      S_BRANCH: begin
        w_alu_src_b  = SRCB_IMM;
        w_result_src = RES_ALURESULT;
        w_branch     = 1'b1;
      end
      default: w_next_pc = 1'b0;
    endcase
  end

  // Strobes are held off for the whole time reset_n is low, not just at the edge.
  assign w_pcs          = (w_reg_w & (bus.Rd == PC_REG)) | w_branch;
  assign bus.PCWrite    = reset_n & ((w_pcs & w_cond_ex) | w_next_pc);
  assign bus.IRWrite    = reset_n & w_ir_write;
  assign bus.RegWrite   = reset_n & w_reg_w & w_cond_ex;
  assign bus.MemWrite   = reset_n & w_mem_w & w_cond_ex;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ALUControl = alu_decode(w_alu_op, bus.Funct[4:1]);
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench: an instruction-level reference model queues the expected
// control vector for every cycle; a negedge monitor pops and compares.
module tb_arm_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  arm_multicycle_ctrl_if bus ();

  arm_multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  logic [3:0] m_flags;   // {N,Z,C,V} of the reference model
  logic [1:0] cur_op;

  // Vector order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc RegSrc
  function automatic logic [15:0] mkvec(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [1:0] rs,
                                        input logic sa, input logic [1:0] sb, input logic [1:0] alc,
                                        input logic [1:0] op);
    logic [1:0] rsrc;
    rsrc = {op == 2'b01, op == 2'b10};
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alc, op, rsrc};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] exp_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'd0;
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // One clock: drive handshake inputs, queue the expected outputs, advance.
  task automatic step(input string nm, input logic [15:0] e, input logic mr, input logic [3:0] af);
    bus.MemReady = mr;
    bus.ALUFlags = af;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycles(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++)
      step("reset", mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd0, cur_op),
           1'b1, 4'($urandom));
    reset_n = 1'b1;
    m_flags = 4'b0000;
  endtask

  task automatic run_instr(input logic [31:0] instr, input int stall_f, input int stall_m,
                           input logic [3:0] af_exec, input bit abort_in_memwr);
    logic [3:0] cond, rd, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       cex, wb_pc;
    cond  = instr[31:28];
    op    = instr[27:26];
    funct = instr[25:20];
    rd    = instr[15:12];
    cmd   = funct[4:1];
    cur_op = op;
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    for (int i = 0; i < stall_f; i++)
      step("fetch_stall", mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd0, op),
           1'b0, 4'($urandom));
    step("fetch", mkvec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 2'd2, 2'd0, op),
         1'b1, 4'($urandom));
    cex   = cond_ok(cond, m_flags);
    wb_pc = cex && (rd == 4'd15);
    step("decode", mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd0, op),
         1'($urandom), 4'($urandom));
    case (op)
      2'b01: begin
        step("memadr", mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0, op),
             1'($urandom), 4'($urandom));
        if (funct[0]) begin
          for (int i = 0; i < stall_m; i++)
            step("memrd_stall", mkvec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, op),
                 1'b0, 4'($urandom));
          step("memrd", mkvec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, op),
               1'b1, 4'($urandom));
          step("memwb", mkvec(wb_pc, 1'b0, 1'b0, 1'b0, cex, 2'd1, 1'b0, 2'd0, 2'd0, op),
               1'($urandom), 4'($urandom));
        end else begin
          for (int i = 0; i < stall_m; i++)
            step("memwr_stall", mkvec(1'b0, 1'b1, cex, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, op),
                 1'b0, 4'($urandom));
          if (abort_in_memwr) begin
            rst_cycles(1);
          end else begin
            step("memwr", mkvec(1'b0, 1'b1, cex, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, op),
                 1'b1, 4'($urandom));
          end
        end
      end
      2'b00: begin
        step(funct[5] ? "exec_i" : "exec_r",
             mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, funct[5] ? 2'd1 : 2'd0,
                   exp_alu(cmd), op),
             1'($urandom), af_exec);
        if (funct[0] && cex) begin
          m_flags[3:2] = af_exec[3:2];
          if (cmd == 4'b0100 || cmd == 4'b0010) m_flags[1:0] = af_exec[1:0];
        end
        step("aluwb", mkvec(wb_pc, 1'b0, 1'b0, 1'b0, cex, 2'd0, 1'b0, 2'd0, 2'd0, op),
             1'($urandom), 4'($urandom));
      end
      2'b10: begin
        step("branch", mkvec(cex, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd1, 2'd0, op),
             1'($urandom), 4'($urandom));
      end
      default: begin
      end
    endcase
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  always @(negedge clk) begin
    logic [15:0] e, got;
    string nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got=%b expected=%b", nm, $time, got, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] instr;
    reset_n = 1'b0;
    cur_op  = 2'b00;
    m_flags = 4'b0000;
    bus.Cond = 4'he; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0;
    bus.MemReady = 1'b1; bus.ALUFlags = 4'd0;
    @(posedge clk);
    #1;
    rst_cycles(2);

    run_instr(32'hE2802005, 0, 0, 4'b1111, 1'b0);              // ADD R2,R0,#5
    run_instr(32'h0280F004, 1, 0, 4'b0000, 1'b0);              // ADDEQ PC with Z=0
    run_instr(32'hE0578007, 0, 0, 4'b0100, 1'b0);              // SUBS R8,R7,R7 -> Z=1
    run_instr(32'h1A000003, 0, 0, 4'b0000, 1'b0);              // BNE not taken
    run_instr(32'h0280F004, 0, 0, 4'b0000, 1'b0);              // ADDEQ PC with Z=1
    run_instr(32'hE5837054, 0, 3, 4'b0000, 1'b0);              // STR, 3 stall cycles
    run_instr(32'hE5902060, 2, 2, 4'b0000, 1'b0);              // LDR with stalls
    run_instr(32'hEC000000, 0, 0, 4'b0000, 1'b0);              // Op=11 no-op
    run_instr(32'hF2802005, 0, 0, 4'b1111, 1'b0);              // never-condition
    run_instr(32'hE5837054, 0, 2, 4'b0000, 1'b1);              // reset mid-stall in MEMWR
    run_instr(32'hE2802005, 0, 0, 4'b0000, 1'b0);

    for (int k = 0; k < 300; k++) begin
      instr = $urandom;
      if ($urandom_range(0, 3) == 0) instr[15:12] = 4'd15;
      if ($urandom_range(0, 2) == 0) instr[31:28] = 4'he;
      run_instr(instr, $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom), 1'b0);
    end

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
